// File: rtl/lcd_id_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_id_timing_ctrl_if
//  Description : Pin readback, rescan request and decoded panel ID / timing
//                bundle between the LCD ID sequencer and its consumers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lcd_id_timing_ctrl_if;
    logic [15:0] lcd_rgb_in;
    logic        rescan;
    logic        id_pin_oe;
    logic        id_valid;
    logic        id_err;
    logic [15:0] lcd_id;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic [11:0] h_total;
    logic [11:0] v_total;
    logic [1:0]  pclk_div;

    // Consumer / pin side: supplies readback and rescan, receives the ID.
    modport master (
        output lcd_rgb_in, rescan,
        input  id_pin_oe, id_valid, id_err, lcd_id,
        input  h_disp, v_disp, h_total, v_total, pclk_div
    );

    // Sequencer side.
    modport slave (
        input  lcd_rgb_in, rescan,
        output id_pin_oe, id_valid, id_err, lcd_id,
        output h_disp, v_disp, h_total, v_total, pclk_div
    );
endinterface
`default_nettype wire

// File: rtl/lcd_id_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_id_timing_ctrl
//  Description : Power-up RGB LCD panel identification. Releases the shared
//                data pins, lets them settle, votes over repeated samples of
//                the ID straps, decodes the panel and drives its timing set.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_id_timing_ctrl #(
    parameter int SETTLE_CYC = 1000,
    parameter int SAMPLE_NUM = 8,
    parameter int SAMPLE_GAP = 16,
    parameter int MAX_TRY    = 3
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    lcd_id_timing_ctrl_if.slave bus
);

    localparam int c_WAIT_MAX = (SETTLE_CYC > SAMPLE_GAP) ? SETTLE_CYC : SAMPLE_GAP;
    localparam int c_WAIT_W   = $clog2(c_WAIT_MAX + 1);
    localparam int c_SAMP_W   = $clog2(SAMPLE_NUM + 1);
    localparam int c_TRY_W    = $clog2(MAX_TRY + 1);

    localparam logic [c_WAIT_W-1:0] c_SETTLE_LAST = c_WAIT_W'(SETTLE_CYC - 1);
    localparam logic [c_WAIT_W-1:0] c_GAP_LAST    = c_WAIT_W'(SAMPLE_GAP - 2);
    localparam logic [c_SAMP_W-1:0] c_SAMP_LAST   = c_SAMP_W'(SAMPLE_NUM - 1);
    localparam logic [c_SAMP_W-1:0] c_SAMP_FULL   = c_SAMP_W'(SAMPLE_NUM);
    localparam logic [c_TRY_W-1:0]  c_TRY_LAST    = c_TRY_W'(MAX_TRY - 1);

    // Timing sets: 4342 is also the fallback used on reset and on error.
    localparam logic [15:0] c_ID_4342 = 16'h4342;
    localparam logic [15:0] c_ID_4384 = 16'h4384;
    localparam logic [10:0] c_HD_4342 = 11'd480;
    localparam logic [10:0] c_VD_4342 = 11'd272;
    localparam logic [11:0] c_HT_4342 = 12'd525;
    localparam logic [11:0] c_VT_4342 = 12'd286;
    localparam logic [1:0]  c_PD_4342 = 2'd3;
    localparam logic [10:0] c_HD_4384 = 11'd800;
    localparam logic [10:0] c_VD_4384 = 11'd480;
    localparam logic [11:0] c_HT_4384 = 12'd1056;
    localparam logic [11:0] c_VT_4384 = 12'd525;
    localparam logic [1:0]  c_PD_4384 = 2'd1;

    typedef enum logic [2:0] {
        S_SETTLE = 3'd0,
        S_SAMPLE = 3'd1,
        S_GAP    = 3'd2,
        S_DECODE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_WAIT_W-1:0] r_cnt, w_cnt_nxt;
    logic [c_SAMP_W-1:0] r_samp, w_samp_nxt;
    logic [c_TRY_W-1:0]  r_try, w_try_nxt;
    logic [2:0]          r_ref, w_ref_nxt;
    logic                r_mis, w_mis_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_oe, w_oe_nxt;
    logic                r_err, w_err_nxt;
    logic [15:0]         r_id, w_id_nxt;
    logic [10:0]         r_hd, w_hd_nxt, r_vd, w_vd_nxt;
    logic [11:0]         r_ht, w_ht_nxt, r_vt, w_vt_nxt;
    logic [1:0]          r_pd, w_pd_nxt;
    logic [2:0]          r_sync1, r_sync2;
    logic [2:0]          w_key;

    // Only the three strap bits are of interest; the rest is readback noise.
    logic w_unused;
    assign w_unused = ^bus.lcd_rgb_in;

    // Two-flop synchroniser on the strap bits, ordered {bit4, bit10, bit15}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {bus.lcd_rgb_in[4], bus.lcd_rgb_in[10], bus.lcd_rgb_in[15]};
            r_sync2 <= r_sync1;
        end
    end

    assign w_key = r_sync2;

    // Next-state, counter and output-register logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_samp_nxt  = r_samp;
        w_try_nxt   = r_try;
        w_ref_nxt   = r_ref;
        w_mis_nxt   = r_mis;
        w_valid_nxt = r_valid;
        w_oe_nxt    = r_oe;
        w_err_nxt   = r_err;
        w_id_nxt    = r_id;
        w_hd_nxt    = r_hd;
        w_vd_nxt    = r_vd;
        w_ht_nxt    = r_ht;
        w_vt_nxt    = r_vt;
        w_pd_nxt    = r_pd;
        unique case (r_state)
            S_SETTLE: begin
                if (r_cnt >= c_SETTLE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_SAMPLE: begin
                if (r_samp == '0) begin
                    w_ref_nxt = w_key;
                end else if (w_key != r_ref) begin
                    w_mis_nxt = 1'b1;
                end
                if (r_samp >= c_SAMP_LAST) begin
                    w_samp_nxt  = c_SAMP_FULL;
                    w_state_nxt = S_DECODE;
                end else begin
                    w_samp_nxt  = r_samp + 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt >= c_GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DECODE: begin
                if (r_mis && (r_try < c_TRY_LAST)) begin
                    // Retry without re-settling; this cycle doubles as the
                    // spacing before the new attempt's first sample.
                    w_try_nxt   = r_try + 1'b1;
                    w_mis_nxt   = 1'b0;
                    w_samp_nxt  = '0;
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_valid_nxt = 1'b1;
                    w_oe_nxt    = 1'b1;
                    w_state_nxt = S_DONE;
                    if (!r_mis && (r_ref == 3'b100)) begin
                        w_err_nxt = 1'b0;
                        w_id_nxt  = c_ID_4384;
                        w_hd_nxt  = c_HD_4384;
                        w_vd_nxt  = c_VD_4384;
                        w_ht_nxt  = c_HT_4384;
                        w_vt_nxt  = c_VT_4384;
                        w_pd_nxt  = c_PD_4384;
                    end else begin
                        // Clean 000 decodes to 4342; anything else is an
                        // error that still falls back to the 4342 timing.
                        w_err_nxt = r_mis || (r_ref != 3'b000);
                        w_id_nxt  = (r_mis || (r_ref != 3'b000)) ? 16'h0000 : c_ID_4342;
                        w_hd_nxt  = c_HD_4342;
                        w_vd_nxt  = c_VD_4342;
                        w_ht_nxt  = c_HT_4342;
                        w_vt_nxt  = c_VT_4342;
                        w_pd_nxt  = c_PD_4342;
                    end
                end
            end
            S_DONE: begin
                // ID and timing stay stale until the next decode.
                if (bus.rescan) begin
                    w_valid_nxt = 1'b0;
                    w_oe_nxt    = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_try_nxt   = '0;
                    w_samp_nxt  = '0;
                    w_mis_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SETTLE;
                end
            end
            default: w_state_nxt = S_SETTLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SETTLE;
            r_cnt   <= '0;
            r_samp  <= '0;
            r_try   <= '0;
            r_ref   <= '0;
            r_mis   <= 1'b0;
            r_valid <= 1'b0;
            r_oe    <= 1'b0;
            r_err   <= 1'b0;
            r_id    <= '0;
            r_hd    <= c_HD_4342;
            r_vd    <= c_VD_4342;
            r_ht    <= c_HT_4342;
            r_vt    <= c_VT_4342;
            r_pd    <= c_PD_4342;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_samp  <= w_samp_nxt;
            r_try   <= w_try_nxt;
            r_ref   <= w_ref_nxt;
            r_mis   <= w_mis_nxt;
            r_valid <= w_valid_nxt;
            r_oe    <= w_oe_nxt;
            r_err   <= w_err_nxt;
            r_id    <= w_id_nxt;
            r_hd    <= w_hd_nxt;
            r_vd    <= w_vd_nxt;
            r_ht    <= w_ht_nxt;
            r_vt    <= w_vt_nxt;
            r_pd    <= w_pd_nxt;
        end
    end

    assign bus.id_pin_oe = r_oe;
    assign bus.id_valid  = r_valid;
    assign bus.id_err    = r_err;
    assign bus.lcd_id    = r_id;
    assign bus.h_disp    = r_hd;
    assign bus.v_disp    = r_vd;
    assign bus.h_total   = r_ht;
    assign bus.v_total   = r_vt;
    assign bus.pclk_div  = r_pd;

endmodule
`default_nettype wire

// File: tb/tb_lcd_id_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_id_timing_ctrl
//  Description : Directed vector bench for the LCD panel ID sequencer with
//                hand-written retry, error, rescan and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_id_timing_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    lcd_id_timing_ctrl_if bus ();

    lcd_id_timing_ctrl #(
        .SETTLE_CYC (10),
        .SAMPLE_NUM (4),
        .SAMPLE_GAP (4),
        .MAX_TRY    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pins;
        logic [15:0] id;
        logic        err;
        logic [10:0] hd;
        logic [10:0] vd;
        logic [11:0] ht;
        logic [11:0] vt;
        logic [1:0]  pd;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [15:0] pins);
        rst_n          = 1'b0;
        bus.rescan     = 1'b0;
        bus.lcd_rgb_in = pins;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_4342_fallback(input string tag);
        chk({tag, "_h_disp"},  32'(bus.h_disp),  32'd480);
        chk({tag, "_v_disp"},  32'(bus.v_disp),  32'd272);
        chk({tag, "_h_total"}, 32'(bus.h_total), 32'd525);
        chk({tag, "_v_total"}, 32'(bus.v_total), 32'd286);
        chk({tag, "_pclk"},    32'(bus.pclk_div), 32'd3);
    endtask

    // Steps until id_valid; mode selects per-cycle stimulus applied before edge c.
    task automatic run_valid(input int mode, input int limit, output int at, output logic oe_early);
        at       = -1;
        oe_early = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            case (mode)
                1: bus.lcd_rgb_in = (c >= 12 && c <= 14) ? 16'h0010 : 16'h0000;
                2: bus.lcd_rgb_in = (((c / 4) % 2) == 1) ? 16'h8000 : 16'h0000;
                3: bus.rescan = (c == 1 || c == 11 || c == 14);
                default: ;
            endcase
            tick();
            if (bus.id_pin_oe && !bus.id_valid) oe_early = 1'b1;
            if (bus.id_valid) begin
                at = c;
                break;
            end
        end
        bus.rescan = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   at;
        logic oe_early;
        logic [10:0] hd_hold;

        n_vec  = 0;
        n_fail = 0;

        vecs[0] = '{16'h0000, 16'h4342, 1'b0, 11'd480, 11'd272, 12'd525,  12'd286, 2'd3};
        vecs[1] = '{16'h0010, 16'h4384, 1'b0, 11'd800, 11'd480, 12'd1056, 12'd525, 2'd1};
        vecs[2] = '{16'h0400, 16'h0000, 1'b1, 11'd480, 11'd272, 12'd525,  12'd286, 2'd3};
        vecs[3] = '{16'h8000, 16'h0000, 1'b1, 11'd480, 11'd272, 12'd525,  12'd286, 2'd3};
        vecs[4] = '{16'h8410, 16'h0000, 1'b1, 11'd480, 11'd272, 12'd525,  12'd286, 2'd3};
        vecs[5] = '{16'h7BEF, 16'h4342, 1'b0, 11'd480, 11'd272, 12'd525,  12'd286, 2'd3};
        vecs[6] = '{16'h7BFF, 16'h4384, 1'b0, 11'd800, 11'd480, 12'd1056, 12'd525, 2'd1};
        vecs[7] = '{16'h0410, 16'h0000, 1'b1, 11'd480, 11'd272, 12'd525,  12'd286, 2'd3};

        // Reset state, observed while rst_n is still low.
        rst_n          = 1'b0;
        bus.rescan     = 1'b0;
        bus.lcd_rgb_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_oe",    32'(bus.id_pin_oe), 32'd0);
        chk("rst_err",   32'(bus.id_err), 32'd0);
        chk("rst_id",    32'(bus.lcd_id), 32'd0);
        chk_4342_fallback("rst");

        // Table: stable pins from reset, clean first attempt at cycle 24.
        for (int v = 0; v < 8; v++) begin
            apply_reset(vecs[v].pins);
            run_valid(0, 100, at, oe_early);
            chk($sformatf("v%0d_latency", v), 32'(at), 32'd24);
            chk($sformatf("v%0d_oe_early", v), 32'(oe_early), 32'd0);
            chk($sformatf("v%0d_oe", v), 32'(bus.id_pin_oe), 32'd1);
            chk($sformatf("v%0d_err", v), 32'(bus.id_err), 32'(vecs[v].err));
            chk($sformatf("v%0d_id", v), 32'(bus.lcd_id), 32'(vecs[v].id));
            chk($sformatf("v%0d_hd", v), 32'(bus.h_disp), 32'(vecs[v].hd));
            chk($sformatf("v%0d_vd", v), 32'(bus.v_disp), 32'(vecs[v].vd));
            chk($sformatf("v%0d_ht", v), 32'(bus.h_total), 32'(vecs[v].ht));
            chk($sformatf("v%0d_vt", v), 32'(bus.v_total), 32'(vecs[v].vt));
            chk($sformatf("v%0d_pd", v), 32'(bus.pclk_div), 32'(vecs[v].pd));
            hd_hold = bus.h_disp;
            repeat (3) tick();
            chk($sformatf("v%0d_hold_valid", v), 32'(bus.id_valid), 32'd1);
            chk($sformatf("v%0d_hold_hd", v), 32'(bus.h_disp), 32'(hd_hold));
        end

        // Glitch on the second sample of attempt 1 only: one retry, cycle 38.
        apply_reset(16'h0000);
        run_valid(1, 100, at, oe_early);
        chk("glitch_latency", 32'(at), 32'd38);
        chk("glitch_oe_early", 32'(oe_early), 32'd0);
        chk("glitch_id", 32'(bus.lcd_id), 32'h4342);
        chk("glitch_err", 32'(bus.id_err), 32'd0);

        // Bit 15 toggling every 4 cycles: all three attempts fail, cycle 52.
        apply_reset(16'h0000);
        run_valid(2, 100, at, oe_early);
        chk("toggle_latency", 32'(at), 32'd52);
        chk("toggle_err", 32'(bus.id_err), 32'd1);
        chk("toggle_id", 32'(bus.lcd_id), 32'h0000);
        chk("toggle_oe", 32'(bus.id_pin_oe), 32'd1);
        chk_4342_fallback("toggle");

        // Rescan pulses in SETTLE/SAMPLE/GAP are ignored.
        apply_reset(16'h0000);
        run_valid(3, 100, at, oe_early);
        chk("ign_rescan_latency", 32'(at), 32'd24);
        chk("ign_rescan_id", 32'(bus.lcd_id), 32'h4342);

        // Rescan in DONE with new straps: drop next cycle, stale ID kept.
        bus.lcd_rgb_in = 16'h0010;
        bus.rescan     = 1'b1;
        tick();
        bus.rescan = 1'b0;
        chk("rescan_valid_drop", 32'(bus.id_valid), 32'd0);
        chk("rescan_oe_drop", 32'(bus.id_pin_oe), 32'd0);
        chk("rescan_id_stale", 32'(bus.lcd_id), 32'h4342);
        chk("rescan_hd_stale", 32'(bus.h_disp), 32'd480);
        run_valid(0, 100, at, oe_early);
        chk("rescan_latency", 32'(at), 32'd24);
        chk("rescan_oe_early", 32'(oe_early), 32'd0);
        chk("rescan_id_new", 32'(bus.lcd_id), 32'h4384);
        chk("rescan_hd_new", 32'(bus.h_disp), 32'd800);
        chk("rescan_err", 32'(bus.id_err), 32'd0);

        // Rescan again, then assert reset in mid-GAP between clock edges.
        bus.rescan = 1'b1;
        tick();
        bus.rescan = 1'b0;
        repeat (12) tick();
        chk("gap_id_stale", 32'(bus.lcd_id), 32'h4384);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_id", 32'(bus.lcd_id), 32'h0000);
        chk("async_rst_valid", 32'(bus.id_valid), 32'd0);
        chk("async_rst_oe", 32'(bus.id_pin_oe), 32'd0);
        chk_4342_fallback("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_valid(0, 100, at, oe_early);
        chk("post_rst_latency", 32'(at), 32'd24);
        chk("post_rst_id", 32'(bus.lcd_id), 32'h4384);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
